fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core, directly upstream of the controller. It owns the program counter and issues in-order requests to instruction memory over a valid/ready handshake. Returned words are held in a 2-entry instruction buffer, and the buffer head is presented to decode, including the `op`/`funct3`/`funct7b5` fields the controller consumes. Taken branches and jumps (`PCSrc`) arrive as a redirect that flushes the buffer and discards in-flight wrong-path responses.

---
 rtl/fetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues in-order word
// fetches to instruction memory over a valid/ready handshake, and holds the
// returned words in a 2-entry instruction buffer whose head is presented to
// decode. A redirect (taken branch / jump) flushes the buffer, reloads the PC
// and marks every fetch still in flight so its response is thrown away.
//
// Ports
//   clk              in   clock, all state changes on the rising edge
//   reset            in   synchronous reset, active low
//   imem_req_valid   out  fetch request
//   imem_req_addr    out  fetch address (current pc, word aligned)
//   imem_req_ready   in   memory accepts the request this cycle
//   imem_resp_valid  in   response word valid (in order, >= 1 cycle latency)
//   imem_resp_data   in   response word
//   redirect         in   taken branch/jump this cycle
//   redirect_pc      in   redirect target, bits [1:0] ignored
//   stall            in   decode cannot take the head this cycle
//   instr_valid      out  buffer head valid
//   instr            out  buffer head word, NOP when empty
//   instr_pc         out  PC of buffer head, 0 when empty
//   pc_plus4         out  instr_pc + 4 (mod 2^32)
//   op/funct3/funct7b5 out  decode fields of instr
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus4,
   output logic [6:0]  op,
   output logic [2:0]  funct3,
   output logic        funct7b5
);

   // control state
   logic [31:0] pc;
   logic [1:0]  outstanding;   // accepted requests without a response yet
   logic [1:0]  drop;          // oldest in-flight responses to discard
   logic [1:0]  occ;           // instruction buffer occupancy

   // data state: PCs of in-flight requests (oldest first) and the buffer
   logic [31:0] pcq_p0       [2];
   logic [31:0] ibuf_word_p1 [2];
   logic [31:0] ibuf_pc_p1   [2];

   // next-state values
   logic [31:0] pc_n;
   logic [1:0]  outstanding_n;
   logic [1:0]  drop_n;
   logic [1:0]  occ_n;
   logic [31:0] pcq_n       [2];
   logic [31:0] ibuf_word_n [2];
   logic [31:0] ibuf_pc_n   [2];

   // per-cycle events
   logic        can_pop;
   logic        pop;
   logic        accept;
   logic        discard;
   logic        push;
   logic [2:0]  credit;
   logic [1:0]  pcq_cnt;
   logic [1:0]  ibuf_cnt;
   logic [31:0] redirect_tgt;

   assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

   // ---------------------------------------------------------------------------
   // Request stage: credit check and handshake
   // ---------------------------------------------------------------------------
   always_comb begin
      can_pop = instr_valid && !stall;
      // Every in-flight request owns a buffer slot; a head leaving this cycle
      // frees one, which keeps full-rate fetch with 1-cycle memory.
      credit  = {1'b0, outstanding} + {1'b0, occ} - {2'b00, can_pop};
      imem_req_valid = reset && !redirect && (credit < 3'd2);
      imem_req_addr  = pc;

      accept  = imem_req_valid && imem_req_ready;
      pop     = can_pop && !redirect;
      // A response arriving with a redirect belongs to the old path as well.
      discard = imem_resp_valid && (redirect || (drop != 2'd0));
      push    = imem_resp_valid && !discard;
   end

   always_comb begin
      pc_n          = pc;
      outstanding_n = outstanding + {1'b0, accept} - {1'b0, imem_resp_valid};
      drop_n        = drop;
      occ_n         = occ + {1'b0, push} - {1'b0, pop};

      if (redirect) begin
         pc_n   = redirect_tgt;
         // Everything still in flight after this cycle is wrong-path.
         drop_n = outstanding - {1'b0, imem_resp_valid};
         occ_n  = 2'd0;
      end else begin
         if (accept) begin
            pc_n = pc + 32'd4;
         end
         if (imem_resp_valid && (drop != 2'd0)) begin
            drop_n = drop - 2'd1;
         end
      end
   end

   // PC queue: a response retires the oldest entry, an accept appends.
   always_comb begin
      pcq_n   = pcq_p0;
      pcq_cnt = outstanding - {1'b0, imem_resp_valid};
      if (imem_resp_valid) begin
         pcq_n[0] = pcq_p0[1];
      end
      if (accept) begin
         if (pcq_cnt == 2'd0) begin
            pcq_n[0] = pc;
         end else begin
            pcq_n[1] = pc;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Response stage: instruction buffer (head in entry 0)
   // ---------------------------------------------------------------------------
   always_comb begin
      ibuf_word_n = ibuf_word_p1;
      ibuf_pc_n   = ibuf_pc_p1;
      ibuf_cnt    = occ - {1'b0, pop};
      if (pop) begin
         ibuf_word_n[0] = ibuf_word_p1[1];
         ibuf_pc_n[0]   = ibuf_pc_p1[1];
      end
      if (push) begin
         // The pushed word always belongs to the oldest in-flight request.
         if (ibuf_cnt == 2'd0) begin
            ibuf_word_n[0] = imem_resp_data;
            ibuf_pc_n[0]   = pcq_p0[0];
         end else begin
            ibuf_word_n[1] = imem_resp_data;
            ibuf_pc_n[1]   = pcq_p0[0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc          <= RESET_PC;
         outstanding <= 2'd0;
         drop        <= 2'd0;
         occ         <= 2'd0;
      end else begin
         pc          <= pc_n;
         outstanding <= outstanding_n;
         drop        <= drop_n;
         occ         <= occ_n;
      end
   end

   // Data entries are qualified by outstanding/occ and need no reset.
   always_ff @(posedge clk) begin
      pcq_p0       <= pcq_n;
      ibuf_word_p1 <= ibuf_word_n;
      ibuf_pc_p1   <= ibuf_pc_n;
   end

   // ---------------------------------------------------------------------------
   // Decode stage: registered buffer head only
   // ---------------------------------------------------------------------------
   always_comb begin
      instr_valid = (occ != 2'd0);
      instr       = instr_valid ? ibuf_word_p1[0] : NOP;
      instr_pc    = instr_valid ? ibuf_pc_p1[0]   : 32'd0;
      pc_plus4    = instr_pc + 32'd4;
      op          = instr[6:0];
      funct3      = instr[14:12];
      funct7b5    = instr[30];
   end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Randomized bench for fetch_unit. A memory model answers accepted requests in
// order after a programmable latency. A scoreboard holds every accepted fetch
// (on-path or wrong-path) and the on-path words that should sit at decode; a
// monitor compares the DUT against it every cycle. Inputs change on the
// falling edge, outputs are sampled a few time units later.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc_plus4;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .stall           (stall),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .pc_plus4        (pc_plus4),
      .op              (op),
      .funct3          (funct3),
      .funct7b5        (funct7b5)
   );

   int errors = 0;
   int checks = 0;
   int pops   = 0;
   int mcyc   = 0;

   // instruction memory contents: a function of the address
   function automatic logic [31:0] memword(input logic [31:0] a);
      return a ^ {a[15:0], a[31:16]} ^ 32'h0000_3000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, mcyc);
      end
   endtask

   // ---------------- memory model ----------------
   typedef struct { logic [31:0] addr; int due; } mreq_t;
   mreq_t mq[$];
   int p_ready  = 100;
   int lat_min  = 1;
   int lat_max  = 1;
   int hold_low = 0;
   int last_due = 0;
   int mdue;

   initial begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
   end

   always @(negedge clk) begin
      mcyc++;
      #1;
      if (mq.size() > 0 && mq[0].due <= mcyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = memword(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      if (!reset) begin
         mq.delete();
         last_due = 0;
      end
      if (hold_low > 0) begin
         imem_req_ready = 1'b0;
         hold_low--;
      end else begin
         imem_req_ready = (int'($urandom_range(99)) < p_ready);
      end
      #1;
      if (imem_req_valid && imem_req_ready) begin
         mdue = mcyc + int'($urandom_range(lat_max, lat_min));
         if (mdue <= last_due) mdue = last_due + 1;
         last_due = mdue;
         mq.push_back('{imem_req_addr, mdue});
      end
   end

   // ---------------- scoreboard + monitor ----------------
   typedef struct { bit live; logic [31:0] pc; } fl_t;
   fl_t         infl[$];   // accepted fetches awaiting a response
   logic [31:0] bufq[$];   // on-path PCs that decode should see, in order
   logic [31:0] exp_fetch;
   bit          prev_rst = 1'b0;
   bit          exp_v, do_pop, exp_req, acc;
   logic [31:0] hp, w;
   fl_t         f;

   always @(negedge clk) begin
      #3;
      if (!reset) begin
         chk("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
         if (prev_rst) begin
            chk("instr_valid_in_reset", 32'(instr_valid), 32'd0);
            chk("instr_in_reset", instr, NOP);
            chk("pc_plus4_in_reset", pc_plus4, 32'd4);
         end
         infl.delete();
         bufq.delete();
         exp_fetch = RESET_PC;
         prev_rst  = 1'b1;
      end else begin
         prev_rst = 1'b0;
         exp_v = (bufq.size() > 0);
         chk("instr_valid", 32'(instr_valid), 32'(exp_v));
         if (exp_v) begin
            hp = bufq[0];
            w  = memword(hp);
            chk("instr_pc", instr_pc, hp);
            chk("instr", instr, w);
            chk("pc_plus4", pc_plus4, hp + 32'd4);
            chk("op", 32'(op), 32'(w[6:0]));
            chk("funct3", 32'(funct3), 32'(w[14:12]));
            chk("funct7b5", 32'(funct7b5), 32'(w[30]));
         end else begin
            chk("instr_empty", instr, NOP);
            chk("instr_pc_empty", instr_pc, 32'd0);
            chk("pc_plus4_empty", pc_plus4, 32'd4);
         end
         do_pop  = exp_v && !stall;
         exp_req = !redirect && ((infl.size() + bufq.size() - int'(do_pop)) < 2);
         chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
         if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
         acc = imem_req_valid && imem_req_ready;

         f = '{1'b0, 32'd0};
         if (imem_resp_valid && infl.size() > 0) f = infl.pop_front();

         if (redirect) begin
            foreach (infl[i]) infl[i].live = 1'b0;
            bufq.delete();
            exp_fetch = redirect_pc & ~32'h3;
            if (acc) infl.push_back('{1'b0, imem_req_addr});
         end else begin
            if (do_pop) begin
               void'(bufq.pop_front());
               pops++;
            end
            if (imem_resp_valid && f.live) bufq.push_back(f.pc);
            if (acc) begin
               infl.push_back('{1'b1, exp_fetch});
               exp_fetch = exp_fetch + 32'd4;
            end
         end
         if (acc) chk("inflight_le_2", 32'(infl.size() <= 2), 32'd1);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      repeat (3) @(negedge clk);
      // reset release, 1-cycle memory, no stall
      reset = 1'b1;
      repeat (10) @(negedge clk);
      // stall 5 cycles after fill, then release
      stall = 1'b1;
      repeat (5) @(negedge clk);
      stall = 1'b0;
      repeat (6) @(negedge clk);
      // redirect to 0x100 with slow memory (two requests in flight)
      lat_min = 3; lat_max = 3;
      repeat (8) @(negedge clk);
      redirect = 1'b1; redirect_pc = 32'h0000_0100;
      @(negedge clk);
      redirect = 1'b0;
      repeat (10) @(negedge clk);
      // redirect to 0x203 while a response arrives and the head pops
      lat_min = 1; lat_max = 1;
      repeat (6) @(negedge clk);
      redirect = 1'b1; redirect_pc = 32'h0000_0203;
      @(negedge clk);
      redirect = 1'b0;
      repeat (6) @(negedge clk);
      // ready low 3 cycles, latency 3
      lat_min = 3; lat_max = 3; hold_low = 3;
      repeat (12) @(negedge clk);
      // PC wrap
      lat_min = 1; lat_max = 1;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect = 1'b0;
      repeat (6) @(negedge clk);
      // reset mid-operation with requests in flight
      lat_min = 3; lat_max = 3;
      repeat (6) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            lat_min = int'($urandom_range(2, 1));
            lat_max = lat_min + int'($urandom_range(2));
            case ($urandom_range(2))
               0:       p_ready = 100;
               1:       p_ready = 70;
               default: p_ready = 40;
            endcase
         end
         stall    = ($urandom_range(99) < 25);
         redirect = ($urandom_range(99) < 5) || (redirect && ($urandom_range(1) == 1));
         if (redirect) begin
            case ($urandom_range(7))
               0:       redirect_pc = 32'hFFFF_FFFC;
               1:       redirect_pc = 32'hFFFF_FFF8;
               default: redirect_pc = $urandom;
            endcase
         end
         reset = !($urandom_range(999) < 3);
         if (!reset) redirect = 1'b0;
         @(negedge clk);
      end
      stall = 1'b0; redirect = 1'b0; reset = 1'b1; p_ready = 100;
      repeat (10) @(negedge clk);
      checks++;
      if (pops < 300) begin
         errors++;
         $display("FAIL decode_progress: popped %0d instructions, required at least 300", pops);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
